mem_access_stage: RTL and testbench

Memory-access pipeline stage that sits directly after the execute stage and consumes its memory request, load/store control and write-back packets. It owns a byte-addressable word-organised data RAM, performs byte/half/word stores with lane masking, returns sign- or zero-extended load data, and forwards a completed write-back packet downstream under a valid/ready handshake. Memory latency is parameterised; the stage stalls upstream while an access is in flight.

---
 rtl/rv32_pkg.sv | 39 +++
 rtl/data_ram.sv | 17 +
 rtl/mem_access_stage.sv | 102 ++++++++++
 tb/tb_mem_access_stage.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: load/store encodings, LSU state enum and the packet types shared by the memory stage.
package rv32_pkg;
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b011;
  localparam logic [2:0] LOAD_LHU = 3'b100;
  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;
  typedef enum logic [1:0] {LSU_IDLE, LSU_ACCESS, LSU_RESP} rv32_lsu_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        read_enable;
    logic        write_enable;
  } rv32_mem_packet_t;
  typedef struct packed {
    logic [2:0] load_type;
    logic [1:0] store_type;
  } rv32_ex_control_packet_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        wb_enable;
  } rv32_ex2mem_wb_packet_t;
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [2:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[lane*8 +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    return t == LOAD_LB  ? {{24{b[7]}}, b} :
           t == LOAD_LBU ? {24'd0, b} :
           t == LOAD_LH  ? {{16{h[15]}}, h} :
           t == LOAD_LHU ? {16'd0, h} :
           t == LOAD_LW  ? w : 32'd0;
  endfunction
endpackage

// File: rtl/data_ram.sv
// data_ram: single-port synchronous word RAM with per-byte write enables and registered read.
module data_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     be,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage with lane-masked stores, extended loads and valid/ready write-back.
// Optional MEM_ALIGN_TRAP_EN: misaligned half/word accesses raise misalign_fault and are suppressed.
import rv32_pkg::*;
module mem_access_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  rv32_mem_packet_t        mem_packet,
  input  rv32_ex_control_packet_t ex_control_packet,
  input  rv32_ex2mem_wb_packet_t  wb_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output rv32_ex2mem_wb_packet_t  wb_out,
  output logic                    misalign_fault,
  output logic                    busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  rv32_lsu_state_t         state;
  logic [3:0]              cnt;
  rv32_mem_packet_t        req_mem;
  rv32_ex_control_packet_t req_ctl;
  rv32_ex2mem_wb_packet_t  req_wb, resp_wb;
  logic [AW-1:0]           ram_addr;
  logic [31:0]             rdata, wdata;
  logic [3:0]              be;
  logic                    accept, done, fault, unused_addr;
  assign in_ready = state == LSU_IDLE || (state == LSU_RESP && out_ready);
  assign busy = state != LSU_IDLE;
  assign accept = in_valid && in_ready;
  assign done = state == LSU_ACCESS && cnt == 4'd0;
  assign unused_addr = ^req_mem.addr[31:AW+2];
`ifdef MEM_ALIGN_TRAP_EN
  assign fault = req_mem.write_enable ?
    ((req_ctl.store_type == STORE_SH && req_mem.addr[0]) ||
     (req_ctl.store_type == STORE_SW && req_mem.addr[1:0] != 2'b00)) :
    (((req_ctl.load_type == LOAD_LH || req_ctl.load_type == LOAD_LHU) && req_mem.addr[0]) ||
     (req_ctl.load_type == LOAD_LW && req_mem.addr[1:0] != 2'b00));
`else
  assign fault = 1'b0;
`endif
  // Reading the incoming address on accept makes load data ready by the last ACCESS cycle.
  assign ram_addr = accept ? mem_packet.addr[2 +: AW] : req_mem.addr[2 +: AW];
  always_comb begin
    be = !(rst_n && done && req_mem.write_enable && !fault) ? 4'b0000 :
         req_ctl.store_type == STORE_SB ? 4'b0001 << req_mem.addr[1:0] :
         req_ctl.store_type == STORE_SH ? (req_mem.addr[1] ? 4'b1100 : 4'b0011) :
         req_ctl.store_type == STORE_SW ? 4'b1111 : 4'b0000;
    wdata = req_ctl.store_type == STORE_SB ? {4{req_mem.data[7:0]}} :
            req_ctl.store_type == STORE_SH ? {2{req_mem.data[15:0]}} : req_mem.data;
    resp_wb = req_wb;
    resp_wb.wb_data = req_mem.write_enable ? req_wb.wb_data :
                      load_extend(rdata, req_mem.addr[1:0], req_ctl.load_type);
    resp_wb.wb_enable = req_wb.wb_enable && !fault;
  end
  data_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LSU_IDLE;
      cnt <= 4'd0;
      out_valid <= 1'b0;
      wb_out <= '0;
      misalign_fault <= 1'b0;
      req_mem <= '0;
      req_ctl <= '0;
      req_wb <= '0;
    end else if (accept) begin
      req_mem <= mem_packet;
      req_ctl <= ex_control_packet;
      req_wb <= wb_in;
      misalign_fault <= 1'b0;
      if (mem_packet.write_enable || mem_packet.read_enable) begin
        state <= LSU_ACCESS;
        cnt <= 4'(MEM_LATENCY - 1);
        out_valid <= 1'b0;
      end else begin
        state <= LSU_RESP;
        wb_out <= wb_in;
        out_valid <= 1'b1;
      end
    end else if (done) begin
      state <= LSU_RESP;
      wb_out <= resp_wb;
      out_valid <= 1'b1;
      misalign_fault <= fault;
    end else if (state == LSU_ACCESS) begin
      cnt <= cnt - 4'd1;
    end else if (state == LSU_RESP && out_ready) begin
      state <= LSU_IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors with hand-computed results for the memory-access stage.
import rv32_pkg::*;
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, misalign_fault, busy;
  rv32_mem_packet_t        mem_packet;
  rv32_ex_control_packet_t ex_control_packet;
  rv32_ex2mem_wb_packet_t  wb_in, wb_out;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mem_access_stage #(.DEPTH_WORDS(1024), .MEM_LATENCY(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .mem_packet        (mem_packet),
    .ex_control_packet (ex_control_packet),
    .wb_in             (wb_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .wb_out            (wb_out),
    .misalign_fault    (misalign_fault),
    .busy              (busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic re, input logic we,
                       input logic [2:0] lt, input logic [1:0] st, input logic [31:0] wbd,
                       input logic wbe);
    mem_packet = '{addr: a, data: d, read_enable: re, write_enable: we};
    ex_control_packet = '{load_type: lt, store_type: st};
    wb_in = '{rd: 5'd7, wb_data: wbd, wb_enable: wbe};
  endtask
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] d, input logic re,
                    input logic we, input logic [2:0] lt, input logic [1:0] st,
                    input logic [31:0] wbd, input logic wbe);
    int k;
    drive(a, d, re, we, lt, st, wbd, wbe);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 20);
    check({tag, "_lat"}, 64'(k), (re || we) ? 64'd3 : 64'd1);
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_wb_out", 64'(wb_out), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fault", 64'(misalign_fault), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    op("sw", 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, LOAD_LB, STORE_SW, 32'h1234, 1'b0);
    check("sw_fwd", 64'(wb_out.wb_data), 64'h1234);
    op("lw", 32'h10, 32'h0, 1'b1, 1'b0, LOAD_LW, STORE_SB, 32'h0, 1'b1);
    check("lw_data", 64'(wb_out.wb_data), 64'hDEADBEEF);
    check("lw_rd", 64'(wb_out.rd), 64'd7);
    op("sb", 32'h13, 32'h80, 1'b0, 1'b1, LOAD_LB, STORE_SB, 32'h0, 1'b0);
    op("lb", 32'h13, 32'h0, 1'b1, 1'b0, LOAD_LB, STORE_SB, 32'h0, 1'b1);
    check("lb_data", 64'(wb_out.wb_data), 64'hFFFFFF80);
    op("lbu", 32'h13, 32'h0, 1'b1, 1'b0, LOAD_LBU, STORE_SB, 32'h0, 1'b1);
    check("lbu_data", 64'(wb_out.wb_data), 64'h00000080);
    op("lw2", 32'h10, 32'h0, 1'b1, 1'b0, LOAD_LW, STORE_SB, 32'h0, 1'b1);
    check("lw2_data", 64'(wb_out.wb_data), 64'h80ADBEEF);
    op("sw20", 32'h20, 32'hCAFEF00D, 1'b0, 1'b1, LOAD_LB, STORE_SW, 32'h0, 1'b0);
    op("sh", 32'h22, 32'h8001, 1'b0, 1'b1, LOAD_LB, STORE_SH, 32'h0, 1'b0);
    op("lh", 32'h22, 32'h0, 1'b1, 1'b0, LOAD_LH, STORE_SB, 32'h0, 1'b1);
    check("lh_data", 64'(wb_out.wb_data), 64'hFFFF8001);
    op("lhu", 32'h22, 32'h0, 1'b1, 1'b0, LOAD_LHU, STORE_SB, 32'h0, 1'b1);
    check("lhu_data", 64'(wb_out.wb_data), 64'h00008001);
    op("lw20", 32'h20, 32'h0, 1'b1, 1'b0, LOAD_LW, STORE_SB, 32'h0, 1'b1);
    check("lw20_data", 64'(wb_out.wb_data), 64'h8001F00D);
    op("st11", 32'h20, 32'h11111111, 1'b0, 1'b1, LOAD_LB, 2'b11, 32'h0, 1'b0);
    op("lw20b", 32'h20, 32'h0, 1'b1, 1'b0, LOAD_LW, STORE_SB, 32'h0, 1'b1);
    check("st11_nowrite", 64'(wb_out.wb_data), 64'h8001F00D);
    op("ld101", 32'h20, 32'h0, 1'b1, 1'b0, 3'b101, STORE_SB, 32'hFFFF, 1'b1);
    check("ld101_zero", 64'(wb_out.wb_data), 64'h0);
    op("both", 32'h1010, 32'h55, 1'b1, 1'b1, LOAD_LW, STORE_SW, 32'h42, 1'b0);
    check("both_fwd", 64'(wb_out.wb_data), 64'h42);
    op("wrap", 32'h10, 32'h0, 1'b1, 1'b0, LOAD_LW, STORE_SB, 32'h0, 1'b1);
    check("wrap_data", 64'(wb_out.wb_data), 64'h55);
    op("mis_sw", 32'h11, 32'hA5A5A5A5, 1'b0, 1'b1, LOAD_LB, STORE_SW, 32'h9, 1'b1);
`ifdef MEM_ALIGN_TRAP_EN
    check("mis_fault", 64'(misalign_fault), 64'd1);
    check("mis_wbe", 64'(wb_out.wb_enable), 64'd0);
    op("mis_lw", 32'h10, 32'h0, 1'b1, 1'b0, LOAD_LW, STORE_SB, 32'h0, 1'b1);
    check("mis_word", 64'(wb_out.wb_data), 64'h55);
`else
    check("mis_fault", 64'(misalign_fault), 64'd0);
    check("mis_wbe", 64'(wb_out.wb_enable), 64'd1);
    op("mis_lw", 32'h10, 32'h0, 1'b1, 1'b0, LOAD_LW, STORE_SB, 32'h0, 1'b1);
    check("mis_word", 64'(wb_out.wb_data), 64'hA5A5A5A5);
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h100 + 32'(i) * 32'h11, 1'b1);
      @(negedge clk);
      check("b2b_valid", 64'(out_valid), 64'd1);
      check("b2b_data", 64'(wb_out.wb_data), 64'h100 + 64'(i) * 64'h11);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h777, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h888, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(wb_out.wb_data), 64'h777);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_next", 64'(wb_out.wb_data), 64'h888);
    in_valid = 1'b0;
    @(negedge clk);
    op("sw30", 32'h30, 32'h12345678, 1'b0, 1'b1, LOAD_LB, STORE_SW, 32'h0, 1'b0);
    drive(32'h30, 32'h99, 1'b0, 1'b1, LOAD_LB, STORE_SW, 32'hABC, 1'b1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("access_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_acc_valid", 64'(out_valid), 64'd0);
    check("rst_acc_busy", 64'(busy), 64'd0);
    check("rst_acc_wb", 64'(wb_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    op("lw30", 32'h30, 32'h0, 1'b1, 1'b0, LOAD_LW, STORE_SB, 32'h0, 1'b1);
    check("rst_acc_nowrite", 64'(wb_out.wb_data), 64'h12345678);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
